// File: rtl/mac_array_feeder.sv
// Skew feeder for the systolic minifloat matrix multiplier: buffers A and B, then streams them diagonally.
// Optional build macro FEEDER_AUTOCLR_EN clears both buffers on the DONE cycle.
module mac_array_feeder #(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                load_sel,
  input  logic [$clog2(N)-1:0] load_row,
  input  logic [$clog2(N)-1:0] load_col,
  input  logic [DW-1:0]       load_data,
  input  logic                start,
  output logic                busy,
  output logic                stream_valid,
  output logic                done,
  output logic [N*DW-1:0]     a_out,
  output logic [N*DW-1:0]     b_out
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(3*N-1);
  localparam logic [TW-1:0] LAST_T = TW'(3*N-3);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]      state;
  logic [TW-1:0]   t;
  logic [DW-1:0]   a_buf [N][N];
  logic [DW-1:0]   b_buf [N][N];
  logic [N*DW-1:0] a_lane, b_lane;
  logic [N*DW-1:0] a_rd, b_rd;
  logic            rd_valid, rd_done;
  logic            wr_en;

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  // Out-of-range indices only occur for non-power-of-2 N and are simply dropped.
  assign wr_en = load_valid && load_ready && (int'(load_row) < N) && (int'(load_col) < N);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      case (state)
        IDLE: begin
          t <= '0;
          if (start) state <= STREAM;
        end
        STREAM: begin
          if (t == LAST_T) state <= DONE;
          else             t     <= t + TW'(1);
        end
        DONE: begin
          state <= IDLE;
          t     <= '0;
        end
        default: begin
          state <= IDLE;
          t     <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_buf[i][j] <= '0;
          b_buf[i][j] <= '0;
        end
      end
    end else begin
      if (wr_en) begin
        if (load_sel) b_buf[load_row][load_col] <= load_data;
        else          a_buf[load_row][load_col] <= load_data;
      end
`ifdef FEEDER_AUTOCLR_EN
      if (state == DONE) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            a_buf[i][j] <= '0;
            b_buf[i][j] <= '0;
          end
        end
      end
`else
`endif
    end
  end

  // Element (i,j) sits on the anti-diagonal i+j, so it is due on its lane exactly when t == i+j.
  always_comb begin
    a_lane = '0;
    b_lane = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (t == TW'(i + j)) begin
          a_lane[DW*i +: DW] = a_buf[i][j];
          b_lane[DW*j +: DW] = b_buf[i][j];
        end
      end
    end
  end

  // Buffer read is registered like a RAM port, then the output register drives the array edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd         <= '0;
      b_rd         <= '0;
      rd_valid     <= 1'b0;
      rd_done      <= 1'b0;
      a_out        <= '0;
      b_out        <= '0;
      stream_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      a_rd         <= (state == STREAM) ? a_lane : '0;
      b_rd         <= (state == STREAM) ? b_lane : '0;
      rd_valid     <= (state == STREAM);
      rd_done      <= (state == DONE);
      a_out        <= a_rd;
      b_out        <= b_rd;
      stream_valid <= rd_valid;
      done         <= rd_done;
    end
  end

endmodule
